// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared combinational ALU, with round-robin or fixed-priority grant.
// Latency: a request granted in cycle N shows o_rsp_valid in cycle N+2; the next grant can come no sooner than N+3.
// Backpressure: the response is held stable until i_rsp_ready; while busy or in reset, o_req_ready stays 0.
// Build option: define ALU_ARBITER_PRIO_EN for fixed priority (requester 0 wins ties, no pointer).
module alu_arbiter #(
    parameter int G_N_BIT  = 8,
    parameter int G_OP_BIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [2*G_N_BIT-1:0]  i_req_s1,
    input  logic [2*G_N_BIT-1:0]  i_req_s2,
    input  logic [2*G_OP_BIT-1:0] i_req_op,
    output logic [G_N_BIT-1:0]    o_alu_s1,
    output logic [G_N_BIT-1:0]    o_alu_s2,
    output logic [G_OP_BIT-1:0]   o_alu_op,
    input  logic [G_N_BIT-1:0]    i_alu_res,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [G_N_BIT-1:0]    o_rsp_res,
    output logic                  o_rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [G_N_BIT-1:0]    s1_q, s1_d;
    logic [G_N_BIT-1:0]    s2_q, s2_d;
    logic [G_OP_BIT-1:0]   op_q, op_d;
    logic [G_N_BIT-1:0]    res_q, res_d;
    logic                  id_q, id_d;
    logic                  gnt_vld;
    logic                  gnt_id;
`ifndef ALU_ARBITER_PRIO_EN
    logic                  last_q, last_d;
`endif

    // Pick the winning requester; only meaningful when gnt_vld is set.
    always_comb begin
        gnt_vld = |i_req_valid;
`ifdef ALU_ARBITER_PRIO_EN
        gnt_id  = ~i_req_valid[0];
`else
        if (&i_req_valid) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = ~i_req_valid[0];
        end
`endif
    end

    // Next-state, operand latching, result capture and the combinational grant.
    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        op_d        = op_q;
        res_d       = res_q;
        id_d        = id_q;
        o_req_ready = 2'b00;
`ifndef ALU_ARBITER_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld && !rst) begin
                    o_req_ready[gnt_id] = 1'b1;
                    s1_d    = gnt_id ? i_req_s1[2*G_N_BIT-1:G_N_BIT]   : i_req_s1[G_N_BIT-1:0];
                    s2_d    = gnt_id ? i_req_s2[2*G_N_BIT-1:G_N_BIT]   : i_req_s2[G_N_BIT-1:0];
                    op_d    = gnt_id ? i_req_op[2*G_OP_BIT-1:G_OP_BIT] : i_req_op[G_OP_BIT-1:0];
                    id_d    = gnt_id;
`ifndef ALU_ARBITER_PRIO_EN
                    last_d  = gnt_id;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = i_alu_res;
                state_d = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight operation and clears outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            id_q    <= 1'b0;
`ifndef ALU_ARBITER_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            op_q    <= op_d;
            res_q   <= res_d;
            id_q    <= id_d;
`ifndef ALU_ARBITER_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // ALU operands come straight from the latch, so they hold between operations.
    assign o_alu_s1    = s1_q;
    assign o_alu_s2    = s2_q;
    assign o_alu_op    = op_q;
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_res   = res_q;
    assign o_rsp_id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic against a transaction-level model.
module tb_alu_arbiter;
    localparam int N   = 8;
    localparam int OPB = 2;
`ifdef ALU_ARBITER_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready;
    logic [2*N-1:0]   req_s1, req_s2;
    logic [2*OPB-1:0] req_op;
    logic [N-1:0]     alu_s1, alu_s2, alu_res, rsp_res;
    logic [OPB-1:0]   alu_op;
    logic             rsp_valid, rsp_ready, rsp_id;

    alu_arbiter #(.G_N_BIT(N), .G_OP_BIT(OPB)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_s1(req_s1), .i_req_s2(req_s2), .i_req_op(req_op),
        .o_alu_s1(alu_s1), .o_alu_s2(alu_s2), .o_alu_op(alu_op),
        .i_alu_res(alu_res),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_res(rsp_res), .o_rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    // Shared ALU: 0 add, 1 sub, 2 and, 3 or.
    always_comb begin
        case (alu_op)
            2'd0:    alu_res = alu_s1 + alu_s2;
            2'd1:    alu_res = alu_s1 - alu_s2;
            2'd2:    alu_res = alu_s1 & alu_s2;
            default: alu_res = alu_s1 | alu_s2;
        endcase
    end

    // Transaction-level model: one outstanding operation, visible two cycles after its grant.
    int             vectors = 0;
    int             miscompares = 0;
    int             age;        // -1 idle, 1 executing, 2 response pending
    logic           last;
    logic [N-1:0]   m_s1, m_s2, pend_res;
    logic [OPB-1:0] m_op;
    logic           pend_id;
    int             gnt_log[$];

    function automatic logic [N-1:0] ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[N-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [N-1:0] a, input logic [N-1:0] b, input logic [OPB-1:0] op);
        if (k == 0) begin
            req_s1[N-1:0] = a; req_s2[N-1:0] = b; req_op[OPB-1:0] = op;
        end else begin
            req_s1[2*N-1:N] = a; req_s2[2*N-1:N] = b; req_op[2*OPB-1:OPB] = op;
        end
    endtask

    // One clock: check outputs against the model, take the edge, advance the model.
    task automatic tick();
        logic [1:0]     exp_rdy;
        int             g;
        logic [N-1:0]   a, b;
        logic [OPB-1:0] o;
        #1;
        exp_rdy = 2'b00;
        g = -1;
        if (!rst && age < 0 && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = PRIO ? 0 : (last ? 0 : 1);
            else                    g = req_valid[0] ? 0 : 1;
            exp_rdy[g] = 1'b1;
        end
        chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, age == 2});
        if (age == 2) begin
            chk("rsp_res", {24'd0, rsp_res}, {24'd0, pend_res});
            chk("rsp_id",  {31'd0, rsp_id},  {31'd0, pend_id});
        end
        chk("alu_s1", {24'd0, alu_s1}, {24'd0, m_s1});
        chk("alu_s2", {24'd0, alu_s2}, {24'd0, m_s2});
        chk("alu_op", {30'd0, alu_op}, {30'd0, m_op});
        @(posedge clk);
        if (rst) begin
            age = -1; last = 1'b1; m_s1 = '0; m_s2 = '0; m_op = '0;
        end else if (g >= 0) begin
            a = (g == 1) ? req_s1[2*N-1:N] : req_s1[N-1:0];
            b = (g == 1) ? req_s2[2*N-1:N] : req_s2[N-1:0];
            o = (g == 1) ? req_op[2*OPB-1:OPB] : req_op[OPB-1:0];
            pend_res = ref_alu(int'(o), int'(a), int'(b));
            pend_id  = g[0];
            last     = g[0];
            m_s1 = a; m_s2 = b; m_op = o;
            age = 1;
            gnt_log.push_back(g);
        end else if (age == 1) begin
            age = 2;
        end else if (age == 2 && rsp_ready) begin
            age = -1;
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_g;
        rst = 1'b1; req_valid = 2'b11; req_s1 = '0; req_s2 = '0; req_op = '0; rsp_ready = 1'b1;
        age = -1; last = 1'b1; m_s1 = '0; m_s2 = '0; m_op = '0; pend_res = '0; pend_id = 1'b0;
        @(negedge clk);
        // Reset held with requests pending: no grant may leak out.
        tick(); tick();
        rst = 1'b0; req_valid = 2'b00;
        #1;
        chk("reset_rsp_res", {24'd0, rsp_res}, 32'h0);
        chk("reset_rsp_id",  {31'd0, rsp_id},  32'h0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'h0);

        // Single add: 5 + 3 from requester 0.
        req_valid = 2'b01; set_req(0, 8'h05, 8'h03, 2'd0);
        #1;
        chk("add_ready_N", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        chk("add_valid_N2", {31'd0, rsp_valid}, 32'h1);
        chk("add_res", {24'd0, rsp_res}, 32'h08);
        chk("add_id", {31'd0, rsp_id}, 32'h0);
        tick();

        // Wrapping add: 0xFF + 0x01 truncates to zero.
        req_valid = 2'b10; set_req(1, 8'hFF, 8'h01, 2'd0);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        chk("wrap_res", {24'd0, rsp_res}, 32'h00);
        chk("wrap_id", {31'd0, rsp_id}, 32'h1);
        tick();

        // Fresh reset, then both requesters held valid: grants alternate (or stay on 0).
        rst = 1'b1; tick(); rst = 1'b0;
        gnt_log.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            set_req(0, 8'($urandom), 8'($urandom), 2'($urandom));
            set_req(1, 8'($urandom), 8'($urandom), 2'($urandom));
            tick();
        end
        chk("rr_count", gnt_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            exp_g = PRIO ? 0 : (i % 2);
            chk("rr_grant", gnt_log[i], exp_g);
        end

        // Finish the last of that traffic, then stall the response five cycles.
        req_valid = 2'b00;
        while (age >= 0) tick();
        req_valid = 2'b01; set_req(0, 8'h21, 8'h0F, 2'd1);
        tick();
        req_valid = 2'b11; rsp_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("stall_res", {24'd0, rsp_res}, 32'h12);
        rsp_ready = 1'b1;
        tick();
        // Back in IDLE: requester 0 was served last, so a tie goes to requester 1 under round-robin.
        req_valid = 2'b11;
        #1;
        chk("stall_idle_ready", {30'd0, req_ready}, PRIO ? 32'h1 : 32'h2);
        tick();
        req_valid = 2'b00;
        tick(); tick();

        // Reset during EXEC discards the operation.
        req_valid = 2'b01; set_req(0, 8'h44, 8'h11, 2'd0);
        tick();
        req_valid = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 32'h0);
        chk("abort_res", {24'd0, rsp_res}, 32'h0);
        chk("abort_id", {31'd0, rsp_id}, 32'h0);
        chk("abort_alu_s1", {24'd0, alu_s1}, 32'h0);
        chk("abort_alu_s2", {24'd0, alu_s2}, 32'h0);
        chk("abort_alu_op", {30'd0, alu_op}, 32'h0);
        tick(); tick(); tick();

        // Random traffic with occasional reset and consumer stalls.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            set_req(0, 8'($urandom), 8'($urandom), 2'($urandom));
            set_req(1, 8'($urandom), 8'($urandom), 2'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter G_N_BIT, default 8, giving the operand and result width in bits.
REQ-002 SHALL have parameter G_OP_BIT, default 2, giving the ALU op-code width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_req_valid  in  2  per-requester request valid (bit k = requester k).
REQ-006 SHALL have port o_req_ready  out  2  per-requester request accepted this cycle.
REQ-007 SHALL have port i_req_s1  in  2*G_N_BIT  operand 1 per requester (requester k in slice k).
REQ-008 SHALL have port i_req_s2  in  2*G_N_BIT  operand 2 per requester.
REQ-009 SHALL have port i_req_op  in  2*G_OP_BIT  op code per requester.
REQ-010 SHALL have port o_alu_s1  out  G_N_BIT  operand 1 to the shared ALU.
REQ-011 SHALL have port o_alu_s2  out  G_N_BIT  operand 2 to the shared ALU.
REQ-012 SHALL have port o_alu_op  out  G_OP_BIT  op code to the shared ALU.
REQ-013 SHALL have port i_alu_res  in  G_N_BIT  combinational ALU result.
REQ-014 SHALL have port o_rsp_valid  out  1  response valid.
REQ-015 SHALL have port i_rsp_ready  in  1  response consumer ready.
REQ-016 SHALL have port o_rsp_res  out  G_N_BIT  captured result.
REQ-017 SHALL have port o_rsp_id  out  1  index of the requester owning the response.

Function
REQ-018 SHALL implement an FSM with states IDLE, EXEC, RESP.
REQ-019 In IDLE with any i_req_valid bit set, SHALL grant exactly one requester: o_req_ready is asserted combinationally for that requester only, operands, op and id are latched, and the FSM moves to EXEC.
REQ-020 o_req_ready SHALL be 0 in EXEC and RESP and for non-granted requesters.
REQ-021 In EXEC, SHALL drive o_alu_s1, o_alu_s2 and o_alu_op from the latched registers, capture i_alu_res into the result register at the clock edge, and move to RESP.
REQ-022 In RESP, SHALL assert o_rsp_valid with stable o_rsp_res and o_rsp_id until a cycle with i_rsp_ready=1, then move to IDLE.
REQ-023 Latency: a request accepted in cycle N SHALL produce o_rsp_valid in cycle N+2; minimum issue interval 3 cycles.
REQ-024 o_alu_* SHALL hold the last latched values outside EXEC (no glitching to zero).
REQ-025 Round-robin (default): on simultaneous valid, SHALL grant the requester not granted most recently; a single valid requester is always granted.
REQ-026 The last-grant pointer SHALL update only on grant; after reset requester 0 wins the first tie.
REQ-027 i_req_valid deasserting while not granted SHALL simply drop the request, with no state change.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, o_rsp_valid=0, o_rsp_res=0, o_rsp_id=0, o_alu_s1/s2/op=0, last-grant pointer=1.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-030 o_req_ready SHALL be 0 while rst=1.

Configuration
REQ-031 Macro ALU_ARBITER_PRIO_EN defined: fixed priority, requester 0 always wins ties, pointer logic removed; undefined: round-robin per REQ-025/026.

Verification
REQ-032 After reset, valid=01, s1=0x05, s2=0x03, ALU model add -> ready=01 in cycle N, rsp_valid at N+2, res=0x08, id=0.
REQ-033 valid=11 held continuously, rsp_ready=1 -> grants alternate 0,1,0,1 (round-robin) or 0,0,0 (PRIO_EN).
REQ-034 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, res and id stable; ready=00 throughout; IDLE one cycle after rsp_ready=1.
REQ-035 rst pulsed in EXEC -> next cycle rsp_valid=0, outputs zero, no response for the aborted request.
REQ-036 s1=0xFF, s2=0x01, ALU add wrapping to G_N_BIT -> res=0x00 (result width G_N_BIT, no carry).
